// File: rtl/ift_egress_guard_if.sv
// Stream bundle for the egress guard: tainted word input plus sanitised word output.
// Carries the two valid/ready handshakes; the guard uses the slave modport.
// in_*: upstream word + taint flag; out_*: forwarded untainted word (no taint).
interface ift_egress_guard_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_taint;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_taint, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_taint, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ift_egress_guard.sv
// Purpose: egress sanitiser; buffers {taint,data}, forwards clean words, drops and counts tainted ones.
// Latency: 2 edges minimum (FIFO write, then head load into the output register).
// Backpressure: in_ready low when FIFO full or locked; out_data held while out_valid && !out_ready.
// Ports: clk, rst_n (async active-low); io (slave stream bundle); alarm_clr (pulse);
//        leak_cnt (saturating drop count), alarm (sticky), locked (FSM in LOCK).
module ift_egress_guard #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ift_egress_guard_if.slave   io,
  input  logic                alarm_clr,
  output logic [7:0]          leak_cnt,
  output logic                alarm,
  output logic                locked
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH:0]   head;
  logic             empty, full, push, head_ok, pop_clean, pop_taint, pop;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [7:0]       leak_nxt;
  logic             alarm_nxt;

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign io.in_ready  = !full && (state == RUN);
  assign push         = io.in_valid && io.in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign locked       = (state == LOCK);

  // Tainted heads are discarded regardless of the output register; clean heads
  // only move when the output register is free or draining this cycle.
  assign head_ok   = (state == RUN) && !empty;
  assign pop_taint = head_ok && head[WIDTH];
  assign pop_clean = head_ok && !head[WIDTH] && (!out_valid_q || io.out_ready);
  assign pop       = pop_clean || pop_taint;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {io.in_taint, io.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pop_clean) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head[WIDTH-1:0];
    end else if (out_valid_q && io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // A discard coinciding with a clear counts as the first leak after the clear.
  always_comb begin
    leak_nxt  = leak_cnt;
    alarm_nxt = alarm;
    state_nxt = state;
    if (pop_taint) begin
      leak_nxt  = alarm_clr ? 8'd1 : ((leak_cnt == 8'hFF) ? leak_cnt : leak_cnt + 8'd1);
      alarm_nxt = 1'b1;
    end else if (alarm_clr) begin
      leak_nxt  = 8'd0;
      alarm_nxt = 1'b0;
    end
    case (state)
      RUN:     if (leak_nxt >= 8'(LOCK_THRESH)) state_nxt = LOCK;
      LOCK:    if (alarm_clr) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      leak_cnt <= 8'd0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_nxt;
      leak_cnt <= leak_nxt;
      alarm    <= alarm_nxt;
    end
  end
endmodule
